// File: rtl/imem_loader_if.sv
// Byte-stream handshake into the instruction-memory loader.
// The master drives bytes; the slave accepts them when ready is high.
interface imem_loader_if;
    logic       valid;
    logic [7:0] data;
    logic       ready;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory loader: unpacks a framed byte stream into 32-bit words,
// writes them from address 0 and keeps the core in reset until the checksum matches.
module imem_loader #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Start,
    imem_loader_if.slave       rx,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [31:0]        mem_wdata,
    output logic               core_reset,
    output logic               done,
    output logic               error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN0,
        S_LEN1,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [15:0] DEPTH_LEN = 16'(DEPTH);

    state_t            state_reg;
    logic [15:0]       len_reg;
    logic [ADDR_W:0]   word_idx_reg;
    logic [1:0]        byte_cnt_reg;
    logic [23:0]       shift_reg;
    logic [7:0]        csum_reg;

    logic              xfer;
    logic [ADDR_W:0]   word_idx_next;
    logic [15:0]       len_next;

    assign xfer          = rx.valid & rx.ready;
    assign word_idx_next = word_idx_reg + 1'b1;
    assign len_next      = {rx.data, len_reg[7:0]};

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg    <= S_IDLE;
            len_reg      <= '0;
            word_idx_reg <= '0;
            byte_cnt_reg <= '0;
            shift_reg    <= '0;
            csum_reg     <= '0;
            rx.ready     <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            core_reset   <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            unique case (state_reg)
                S_IDLE, S_DONE, S_ERR: begin
                    if (Start) begin
                        state_reg    <= S_LEN0;
                        rx.ready     <= 1'b1;
                        word_idx_reg <= '0;
                        byte_cnt_reg <= '0;
                        csum_reg     <= '0;
                        core_reset   <= 1'b1;
                        done         <= 1'b0;
                        error        <= 1'b0;
                    end
                end
                S_LEN0: begin
                    if (xfer) begin
                        len_reg[7:0] <= rx.data;
                        csum_reg     <= csum_reg ^ rx.data;
                        state_reg    <= S_LEN1;
                    end
                end
                S_LEN1: begin
                    if (xfer) begin
                        len_reg[15:8] <= rx.data;
                        csum_reg      <= csum_reg ^ rx.data;
                        if (len_next > DEPTH_LEN) begin
                            state_reg <= S_ERR;
                            rx.ready  <= 1'b0;
                            error     <= 1'b1;
                        end else if (len_next == 16'd0) begin
                            state_reg <= S_CSUM;
                        end else begin
                            state_reg <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (xfer) begin
                        csum_reg     <= csum_reg ^ rx.data;
                        byte_cnt_reg <= byte_cnt_reg + 2'd1;
                        shift_reg    <= {shift_reg[15:0], rx.data};
                        // Fourth byte completes the word; write it on the next cycle.
                        if (byte_cnt_reg == 2'd3) begin
                            mem_we       <= 1'b1;
                            mem_addr     <= word_idx_reg[ADDR_W-1:0];
                            mem_wdata    <= {shift_reg, rx.data};
                            word_idx_reg <= word_idx_next;
                            if (16'(word_idx_next) == len_reg) begin
                                state_reg <= S_CSUM;
                            end
                        end
                    end
                end
                S_CSUM: begin
                    if (xfer) begin
                        rx.ready <= 1'b0;
                        if (rx.data == csum_reg) begin
                            state_reg  <= S_DONE;
                            done       <= 1'b1;
                            core_reset <= 1'b0;
                        end else begin
                            state_reg <= S_ERR;
                            error     <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                    rx.ready  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader: frames are driven over the
// byte stream and compared with a frame-level model of the expected writes.
module tb_imem_loader;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 256;

    typedef logic [7:0] bq_t[$];

    logic              Clk = 1'b0;
    logic              Reset;
    logic              Start;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              core_reset;
    logic              done;
    logic              error;

    imem_loader_if rx ();

    imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Start      (Start),
        .rx         (rx),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .core_reset (core_reset),
        .done       (done),
        .error      (error)
    );

    always #5 Clk = ~Clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Observed traffic, sampled just before each rising edge.
    int                acc_cyc_q[$];
    int                wr_cyc_q[$];
    logic [ADDR_W-1:0] wr_addr_q[$];
    logic [31:0]       wr_data_q[$];

    always @(posedge Clk) begin
        if (rx.valid && rx.ready) acc_cyc_q.push_back(cyc);
        if (mem_we) begin
            wr_cyc_q.push_back(cyc);
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_wdata);
        end
        cyc++;
    end

    // Frame-level reference: word list, length failure, checksum failure.
    logic [31:0] exp_words[$];
    int          exp_err;
    int          exp_len_fail;

    task automatic model(input bq_t f);
        int n;
        logic [7:0] x;
        exp_words.delete();
        n = int'(f[0]) + 256 * int'(f[1]);
        if (n > DEPTH) begin
            exp_len_fail = 1;
            exp_err      = 1;
            return;
        end
        exp_len_fail = 0;
        x = 8'h00;
        for (int i = 0; i < 2 + 4 * n; i++) x ^= f[i];
        for (int w = 0; w < n; w++)
            exp_words.push_back({f[2+4*w], f[3+4*w], f[4+4*w], f[5+4*w]});
        exp_err = (x != f[2+4*n]) ? 1 : 0;
    endtask

    task automatic mk_frame(input int n, input int good, output bq_t f);
        logic [7:0] x;
        logic [7:0] b;
        f.delete();
        f.push_back(8'(n));
        f.push_back(8'(n >> 8));
        for (int i = 0; i < 4 * n; i++) begin
            b = 8'($urandom);
            f.push_back(b);
        end
        x = 8'h00;
        foreach (f[i]) x ^= f[i];
        f.push_back(good ? x : (x ^ 8'(1 << $urandom_range(0, 7))));
    endtask

    task automatic pulse_start();
        @(negedge Clk);
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
    endtask

    task automatic send_bytes(input bq_t f, input int count, input int rnd_valid, output int ok);
        int t;
        ok = 1;
        for (int i = 0; i < count; i++) begin
            @(negedge Clk);
            if (rnd_valid != 0) begin
                while ($urandom_range(0, 2) == 0) begin
                    rx.valid = 1'b0;
                    rx.data  = 8'($urandom);
                    @(negedge Clk);
                end
            end
            rx.valid = 1'b1;
            rx.data  = f[i];
            t = 0;
            while (!rx.ready) begin
                @(negedge Clk);
                t++;
                if (t > 1000) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL handshake_timeout byte %0d: rx_ready=0 required 1", i);
                    rx.valid = 1'b0;
                    ok = 0;
                    return;
                end
            end
            @(posedge Clk);
        end
        @(negedge Clk);
        rx.valid = 1'b0;
    endtask

    task automatic test_frame(input string tag, input bq_t f, input int rnd);
        int ok, wb, ab, nbytes, nw;
        model(f);
        wb = wr_data_q.size();
        ab = acc_cyc_q.size();
        nbytes = (exp_len_fail != 0) ? 2 : f.size();
        pulse_start();
        send_bytes(f, nbytes, rnd, ok);
        if (ok == 0) return;

        n_cmp++;
        if (acc_cyc_q.size() - ab !== nbytes) begin
            n_bad++;
            $display("FAIL %s accept_count: got %0d required %0d", tag, acc_cyc_q.size() - ab, nbytes);
        end
        n_cmp++;
        if (wr_data_q.size() - wb !== exp_words.size()) begin
            n_bad++;
            $display("FAIL %s write_count: got %0d required %0d", tag, wr_data_q.size() - wb, exp_words.size());
        end
        nw = wr_data_q.size() - wb;
        if (nw > exp_words.size()) nw = exp_words.size();
        for (int w = 0; w < nw; w++) begin
            n_cmp++;
            if (wr_addr_q[wb+w] !== ADDR_W'(w)) begin
                n_bad++;
                $display("FAIL %s addr[%0d]: got %0d required %0d", tag, w, wr_addr_q[wb+w], w);
            end
            n_cmp++;
            if (wr_data_q[wb+w] !== exp_words[w]) begin
                n_bad++;
                $display("FAIL %s data[%0d]: got %08h required %08h", tag, w, wr_data_q[wb+w], exp_words[w]);
            end
            if (ab + 5 + 4 * w < acc_cyc_q.size()) begin
                n_cmp++;
                if (wr_cyc_q[wb+w] !== acc_cyc_q[ab+5+4*w] + 1) begin
                    n_bad++;
                    $display("FAIL %s latency[%0d]: write cycle %0d required %0d", tag, w,
                             wr_cyc_q[wb+w], acc_cyc_q[ab+5+4*w] + 1);
                end
            end
        end
        n_cmp++;
        if ({done, error, core_reset, rx.ready} !== {exp_err == 0, exp_err != 0, exp_err != 0, 1'b0}) begin
            n_bad++;
            $display("FAIL %s status{done,error,core_reset,rx_ready}: got %b required %b", tag,
                     {done, error, core_reset, rx.ready},
                     {exp_err == 0, exp_err != 0, exp_err != 0, 1'b0});
        end
        $display("%s: N_words=%0d writes=%0d done=%b error=%b core_reset=%b", tag,
                 exp_words.size(), wr_data_q.size() - wb, done, error, core_reset);
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        Start = 1'b1;
        rx.valid = 1'b0;
        rx.data  = 8'h00;
        repeat (3) @(negedge Clk);
        n_cmp++;
        if ({rx.ready, mem_we, core_reset, done, error} !== 5'b00100) begin
            n_bad++;
            $display("FAIL reset_flags{ready,we,core_reset,done,error}: got %b required 00100",
                     {rx.ready, mem_we, core_reset, done, error});
        end
        n_cmp++;
        if (mem_addr !== '0) begin
            n_bad++;
            $display("FAIL reset_mem_addr: got %0d required 0", mem_addr);
        end
        n_cmp++;
        if (mem_wdata !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_mem_wdata: got %08h required 00000000", mem_wdata);
        end
        Reset = 1'b0;
        Start = 1'b0;
        repeat (2) @(negedge Clk);
        n_cmp++;
        if (rx.ready !== 1'b0 || core_reset !== 1'b1) begin
            n_bad++;
            $display("FAIL idle_after_reset{ready,core_reset}: got %b%b required 01", rx.ready, core_reset);
        end
        $display("test_reset: ready=%b core_reset=%b done=%b error=%b", rx.ready, core_reset, done, error);
    endtask

    task automatic test_reset_mid_load();
        bq_t f;
        int ok;
        f = {8'h02, 8'h00, 8'h4C, 8'h40, 8'h00, 8'h02, 8'h4C, 8'h80, 8'h00, 8'h06, 8'hC6};
        pulse_start();
        send_bytes(f, 6, 0, ok);
        if (ok == 0) return;
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        n_cmp++;
        if ({rx.ready, mem_we, core_reset, done, error} !== 5'b00100) begin
            n_bad++;
            $display("FAIL midreset_flags{ready,we,core_reset,done,error}: got %b required 00100",
                     {rx.ready, mem_we, core_reset, done, error});
        end
        n_cmp++;
        if (mem_wdata !== 32'h0 || mem_addr !== '0) begin
            n_bad++;
            $display("FAIL midreset_mem: got addr=%0d data=%08h required 0/00000000", mem_addr, mem_wdata);
        end
        $display("test_reset_mid_load: reset after 6 bytes, ready=%b core_reset=%b", rx.ready, core_reset);
        test_frame("reload_after_reset", f, 0);
    endtask

    initial begin
        bq_t f;
        Reset    = 1'b1;
        Start    = 1'b0;
        rx.valid = 1'b0;
        rx.data  = 8'h00;

        test_reset();

        f = {8'h02, 8'h00, 8'h4C, 8'h40, 8'h00, 8'h02, 8'h4C, 8'h80, 8'h00, 8'h06, 8'hC6};
        test_frame("test_basic", f, 0);
        f[10] = 8'hC7;
        test_frame("test_bad_csum", f, 0);
        f = {8'h01, 8'h01};
        test_frame("test_len_overflow", f, 0);
        f = {8'h00, 8'h00, 8'h00};
        test_frame("test_empty", f, 0);
        f = {8'h02, 8'h00, 8'h4C, 8'h40, 8'h00, 8'h02, 8'h4C, 8'h80, 8'h00, 8'h06, 8'hC6};
        test_frame("test_random_valid", f, 1);
        test_reset_mid_load();

        for (int k = 0; k < 8; k++) begin
            mk_frame($urandom_range(0, 6), ($urandom_range(0, 3) != 0) ? 1 : 0, f);
            test_frame($sformatf("test_random_%0d", k), f, 1);
        end
        mk_frame(DEPTH, 1, f);
        test_frame("test_full_depth", f, 0);
        f = {8'h03, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88,
             8'h99, 8'hAA, 8'hBB, 8'hCC, 8'h00};
        test_frame("test_back_to_back", f, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

endmodule
